loop_osc_monitor: RTL

Sequential observer for the combinational-loop benchmark circuits. It samples one loop net, which is asynchronous to the clock and may be free-running, over a programmed window of clock cycles. It reports whether the net oscillated, how many edges it made, the shortest edge-to-edge gap, and its final level. It sits in the loop-checker benchmark harness as the reading end of the loop netlists: the netlists drive nets, and this block reads and classifies them.

---
 rtl/loop_mon_pkg.sv | 25 ++
 rtl/loop_sync_edge.sv | 29 ++
 rtl/loop_osc_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/loop_mon_pkg.sv
// Shared types and helpers for the loop oscillation monitor: FSM states,
// saturating increment and all-ones masks for arbitrary widths up to 32 bits.
package loop_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } mon_state_t;

    function automatic logic [31:0] all_ones(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Increment v but stop at the largest value representable in w bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] lim;
        lim = all_ones(w);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/loop_sync_edge.sv
// Multi-stage synchronizer for an asynchronous loop net, followed by an
// edge-detect register comparing the synchronized level with its last value.
module loop_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic probe,
    output logic sync_level,
    output logic sync_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], probe};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign sync_edge  = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/loop_osc_monitor.sv
// Windowed observer for a free-running loop net: counts synchronized edges,
// tracks the shortest edge-to-edge gap and reports through a valid/ready pair.
module loop_osc_monitor
    import loop_mon_pkg::*;
#(
    parameter int WIN_W       = 16,
    parameter int CNT_W       = 16,
    parameter int OSC_THRESH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             probe,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_edges,
    output logic             res_osc,
    output logic             res_level,
    output logic [WIN_W-1:0] res_min_gap
);

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
    localparam logic [WIN_W-1:0] WIN_ONES = WIN_W'(all_ones(WIN_W));
    localparam logic [31:0]      OSC_T    = 32'(OSC_THRESH);

    mon_state_t       state;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] meas_cnt;
    logic [ARM_W-1:0] arm_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [WIN_W-1:0] gap_cnt;
    logic [WIN_W-1:0] min_gap;

    logic             sync_level;
    logic             sync_edge;

    logic [CNT_W-1:0] edge_cnt_nxt;
    logic [WIN_W-1:0] gap_cnt_nxt;
    logic [WIN_W-1:0] gap_plus;
    logic [WIN_W-1:0] min_gap_nxt;

    loop_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .probe      (probe),
        .sync_level (sync_level),
        .sync_edge  (sync_edge)
    );

    // Next-cycle counter values, so the final window cycle is included in the result.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        gap_cnt_nxt  = WIN_W'(sat_inc(32'(gap_cnt), WIN_W));
        gap_plus     = WIN_W'(sat_inc(32'(gap_cnt), WIN_W));
        min_gap_nxt  = min_gap;
        if (sync_edge) begin
            edge_cnt_nxt = CNT_W'(sat_inc(32'(edge_cnt), CNT_W));
            gap_cnt_nxt  = '0;
            if (edge_cnt != '0 && gap_plus < min_gap) begin
                min_gap_nxt = gap_plus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_edges   <= '0;
            res_osc     <= 1'b0;
            res_level   <= 1'b0;
            res_min_gap <= WIN_ONES;
            win_q       <= '0;
            meas_cnt    <= '0;
            arm_cnt     <= '0;
            edge_cnt    <= '0;
            gap_cnt     <= '0;
            min_gap     <= WIN_ONES;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        win_q    <= win_len;
                        arm_cnt  <= '0;
                        edge_cnt <= '0;
                        gap_cnt  <= '0;
                        min_gap  <= WIN_ONES;
                        busy     <= 1'b1;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    arm_cnt <= arm_cnt + 1'b1;
                    if (arm_cnt == ARM_LAST) begin
                        meas_cnt <= win_q;
                        if (win_q == '0) begin
                            res_edges   <= '0;
                            res_osc     <= 1'b0;
                            res_level   <= sync_level;
                            res_min_gap <= WIN_ONES;
                            res_valid   <= 1'b1;
                            state       <= REPORT;
                        end else begin
                            state <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    edge_cnt <= edge_cnt_nxt;
                    gap_cnt  <= gap_cnt_nxt;
                    min_gap  <= min_gap_nxt;
                    meas_cnt <= meas_cnt - 1'b1;
                    if (meas_cnt == WIN_W'(1)) begin
                        res_edges   <= edge_cnt_nxt;
                        res_osc     <= (32'(edge_cnt_nxt) >= OSC_T);
                        res_level   <= sync_level;
                        res_min_gap <= min_gap_nxt;
                        res_valid   <= 1'b1;
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
